// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a load handshake and a shift_en bit-rate strobe.
// A new word can be loaded on the cycle that consumes the previous word's last bit, so there is no gap.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no word in flight; sout_valid=0, load_ready=1
// ST_SHIFT | word bit r_cnt is on sout; it advances when shift_en=1
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic             r_sout;
    logic             r_valid;

    logic             w_last;
    logic             w_load;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_din_rest;
    logic [WIDTH-1:0] w_sreg_shifted;

    assign w_last     = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST) && shift_en;
    assign load_ready = !res && ((r_state == ST_IDLE) || w_last);
    assign w_load     = load_valid && load_ready;
    assign done       = !res && w_last;

    // The first bit goes straight to sout on load; r_sreg keeps only the bits still to be sent.
    assign w_first_bit    = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign w_din_rest     = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
    assign w_next_bit     = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign w_sreg_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_sout  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_sreg  <= w_din_rest;
            r_sout  <= w_first_bit;
            r_valid <= 1'b1;
        end else if ((r_state == ST_SHIFT) && shift_en) begin
            if (r_cnt == CNT_LAST) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_sreg  <= '0;
                r_sout  <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_sreg <= w_sreg_shifted;
                r_sout <= w_next_bit;
            end
        end
    end

    assign sout       = r_sout;
    assign sout_valid = r_valid;

endmodule
